// File: rtl/vospi_pkg.sv
// Shared constants, packet-ID field helpers and FSM state type for the VoSPI frame assembler.
package vospi_pkg;

    localparam int PACKETS_PER_FRAME = 60;
    localparam int PAYLOAD_BYTES     = 160;
    localparam int ROW_W             = 6;
    localparam int COL_W             = 7;
    localparam int ID_NUM_W          = 12;

    localparam logic [3:0] DISCARD_NIBBLE = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DROP = 2'd2
    } state_e;

    function automatic logic id_is_discard(input logic [15:0] id);
        return id[11:8] == DISCARD_NIBBLE;
    endfunction

    function automatic logic [ID_NUM_W-1:0] id_number(input logic [15:0] id);
        return id[11:0];
    endfunction

endpackage

// File: rtl/vospi_pixel_packer.sv
// Pairs payload bytes into big-endian 16-bit pixels and tracks the byte/column position in a packet.
module vospi_pixel_packer
    import vospi_pkg::*;
#(
    parameter int payload_bytes_p = PAYLOAD_BYTES,
    parameter int cnt_width_p     = $clog2(PAYLOAD_BYTES + 1)
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   clear_i,
    input  logic                   byte_valid_i,
    input  logic [7:0]             byte_i,
    input  logic [ROW_W-1:0]       row_i,
    output logic [cnt_width_p-1:0] byte_count_o,
    output logic                   pixel_valid_o,
    output logic [15:0]            pixel_o,
    output logic [ROW_W-1:0]       row_o,
    output logic [COL_W-1:0]       col_o
);

    logic [cnt_width_p-1:0] cnt_q, cnt_d;
    logic [7:0]             msb_q, msb_d;
    logic                   valid_q, valid_d;
    logic [15:0]            pixel_q, pixel_d;
    logic [ROW_W-1:0]       row_q, row_d;
    logic [COL_W-1:0]       col_q, col_d;

    always_comb begin
        cnt_d   = cnt_q;
        msb_d   = msb_q;
        valid_d = 1'b0;
        pixel_d = pixel_q;
        row_d   = row_q;
        col_d   = col_q;
        if (clear_i) begin
            cnt_d = '0;
            msb_d = '0;
        end else if (byte_valid_i && (cnt_q < cnt_width_p'(payload_bytes_p))) begin
            cnt_d = cnt_q + cnt_width_p'(1);
            if (!cnt_q[0]) begin
                msb_d = byte_i;
            end else begin
                valid_d = 1'b1;
                pixel_d = {msb_q, byte_i};
                row_d   = row_i;
                col_d   = COL_W'(cnt_q >> 1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q   <= '0;
            msb_q   <= '0;
            valid_q <= 1'b0;
            pixel_q <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            msb_q   <= msb_d;
            valid_q <= valid_d;
            pixel_q <= pixel_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    assign byte_count_o  = cnt_q;
    assign pixel_valid_o = valid_q;
    assign pixel_o       = pixel_q;
    assign row_o         = row_q;
    assign col_o         = col_q;

endmodule

// File: rtl/vospi_frame_assembler.sv
// Checks VoSPI packet sequencing, drops discard packets, emits row/column-tagged pixels and
// requests a front-end resync on sequence or length violations.
module vospi_frame_assembler
    import vospi_pkg::*;
#(
    parameter int packets_per_frame_p = PACKETS_PER_FRAME,
    parameter int payload_bytes_p     = PAYLOAD_BYTES,
    parameter int err_width_p         = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   id_valid_i,
    input  logic [15:0]            id_i,
    input  logic                   byte_valid_i,
    input  logic [7:0]             byte_i,
    output logic                   pixel_valid_o,
    output logic [15:0]            pixel_o,
    output logic [ROW_W-1:0]       row_o,
    output logic [COL_W-1:0]       col_o,
    output logic                   frame_done_o,
    output logic                   discard_o,
    output logic                   resync_o,
    output logic [err_width_p-1:0] err_count_o
);

    localparam int CNT_W = $clog2(payload_bytes_p + 1);

    generate
        if (packets_per_frame_p < 1 || packets_per_frame_p > 64 ||
            payload_bytes_p < 2 || payload_bytes_p / 2 > 128 || (payload_bytes_p % 2) != 0) begin : g_bad_params
            $error("vospi_frame_assembler: packets_per_frame_p/payload_bytes_p out of range");
        end
    endgenerate

    state_e                state_q, state_d;
    logic [ID_NUM_W-1:0]   expected_q, expected_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [err_width_p-1:0] err_q, err_d;
    logic                  discard_q, discard_d;
    logic                  resync_q, resync_d;
    logic                  frame_done_q, frame_done_d;
    logic                  ev_discard, ev_resync, ev_frame_end;
    logic                  byte_take, last_byte, short_pkt, in_frame, seq_ok;
    logic [CNT_W-1:0]      byte_count;
    logic [ID_NUM_W-1:0]   num;

    assign num      = id_number(id_i);
    assign seq_ok   = (num == expected_q);
    assign in_frame = (expected_q != '0);
    assign short_pkt = (byte_count < CNT_W'(payload_bytes_p));

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            expected_q <= '0;
            row_q      <= '0;
        end else begin
            state_q    <= state_d;
            expected_q <= expected_d;
            row_q      <= row_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        expected_d   = expected_q;
        row_d        = row_q;
        ev_discard   = 1'b0;
        ev_resync    = 1'b0;
        ev_frame_end = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (id_valid_i) begin
                    if (id_is_discard(id_i)) begin
                        ev_discard = 1'b1;
                        state_d    = ST_DROP;
                    end else if (num == '0) begin
                        expected_d = ID_NUM_W'(1);
                        row_d      = '0;
                        state_d    = ST_RECV;
                    end
                end
            end
            ST_RECV: begin
                if (id_valid_i) begin
                    if (short_pkt || (!id_is_discard(id_i) && !seq_ok)) begin
                        ev_resync  = 1'b1;
                        expected_d = '0;
                        state_d    = ST_IDLE;
                    end else if (id_is_discard(id_i)) begin
                        ev_discard = 1'b1;
                        state_d    = ST_DROP;
                    end else begin
                        expected_d = expected_q + ID_NUM_W'(1);
                        row_d      = num[ROW_W-1:0];
                    end
                end else if (last_byte && row_q == ROW_W'(packets_per_frame_p - 1)) begin
                    ev_frame_end = 1'b1;
                    expected_d   = '0;
                    state_d      = ST_IDLE;
                end
            end
            ST_DROP: begin
                // Outside a frame, an unexpected number just falls back to IDLE silently.
                if (id_valid_i) begin
                    if (id_is_discard(id_i)) begin
                        ev_discard = 1'b1;
                    end else if (seq_ok) begin
                        expected_d = expected_q + ID_NUM_W'(1);
                        row_d      = num[ROW_W-1:0];
                        state_d    = ST_RECV;
                    end else begin
                        ev_resync  = in_frame;
                        expected_d = '0;
                        state_d    = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        byte_take    = (state_q == ST_RECV) && byte_valid_i && !id_valid_i;
        last_byte    = byte_take && (byte_count == CNT_W'(payload_bytes_p - 1));
        discard_d    = ev_discard;
        resync_d     = ev_resync;
        frame_done_d = ev_frame_end;
        err_d        = err_q;
        if (ev_resync && err_q != '1) begin
            err_d = err_q + err_width_p'(1);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            discard_q    <= 1'b0;
            resync_q     <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= '0;
        end else begin
            discard_q    <= discard_d;
            resync_q     <= resync_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    vospi_pixel_packer #(
        .payload_bytes_p (payload_bytes_p),
        .cnt_width_p     (CNT_W)
    ) u_packer (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .clear_i       (id_valid_i),
        .byte_valid_i  (byte_take),
        .byte_i        (byte_i),
        .row_i         (row_q),
        .byte_count_o  (byte_count),
        .pixel_valid_o (pixel_valid_o),
        .pixel_o       (pixel_o),
        .row_o         (row_o),
        .col_o         (col_o)
    );

    assign frame_done_o = frame_done_q;
    assign discard_o    = discard_q;
    assign resync_o     = resync_q;
    assign err_count_o  = err_q;

endmodule

// File: tb/tb_vospi_frame_assembler.sv
// Directed bench for the VoSPI frame assembler: full frames, discards, sequence and length faults, reset, saturation.
module tb_vospi_frame_assembler;

    localparam int PPF = 60;
    localparam int PB  = 160;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        id_valid_i;
    logic [15:0] id_i;
    logic        byte_valid_i;
    logic [7:0]  byte_i;
    logic        pixel_valid_o;
    logic [15:0] pixel_o;
    logic [5:0]  row_o;
    logic [6:0]  col_o;
    logic        frame_done_o;
    logic        discard_o;
    logic        resync_o;
    logic [7:0]  err_count_o;

    int checks = 0;
    int errors = 0;
    int pix_cnt, disc_cnt, rs_cnt, fd_cnt;
    int row_pix [64];
    logic [5:0] exp_row = '0;
    logic [6:0] col_exp = '0;

    always #5 clk_i = ~clk_i;

    vospi_frame_assembler #(
        .packets_per_frame_p (PPF),
        .payload_bytes_p     (PB),
        .err_width_p         (8)
    ) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .id_valid_i    (id_valid_i),
        .id_i          (id_i),
        .byte_valid_i  (byte_valid_i),
        .byte_i        (byte_i),
        .pixel_valid_o (pixel_valid_o),
        .pixel_o       (pixel_o),
        .row_o         (row_o),
        .col_o         (col_o),
        .frame_done_o  (frame_done_o),
        .discard_o     (discard_o),
        .resync_o      (resync_o),
        .err_count_o   (err_count_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic clr_counts();
        pix_cnt = 0; disc_cnt = 0; rs_cnt = 0; fd_cnt = 0;
        for (int i = 0; i < 64; i++) row_pix[i] = 0;
    endtask

    // Called once per cycle at the falling edge; outputs reflect the inputs of the previous cycle.
    task automatic sample();
        if (pixel_valid_o) begin
            chk("pixel", {row_o, col_o, pixel_o}, {exp_row, col_exp, exp_row, col_exp, 3'b000});
            $display("pixel row=%0d col=%0d data=%04h", row_o, col_o, pixel_o);
            col_exp++;
            pix_cnt++;
            row_pix[row_o]++;
        end
        if (discard_o) disc_cnt++;
        if (resync_o) rs_cnt++;
        if (frame_done_o) begin
            fd_cnt++;
            chk("frame_done_pos", {pixel_valid_o, row_o, col_o}, {1'b1, 6'd59, 7'd79});
        end
    endtask

    task automatic tick(input logic idv, input logic [15:0] id, input logic bv, input logic [7:0] b,
                        input bit accept);
        @(negedge clk_i);
        sample();
        if (accept) begin
            exp_row = id[5:0];
            col_exp = '0;
        end
        id_valid_i   = idv;
        id_i         = id;
        byte_valid_i = bv;
        byte_i       = b;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 16'h0, 1'b0, 8'h0, 1'b0);
    endtask

    task automatic send_packet(input logic [15:0] id, input int nbytes, input bit accept, input bit junk);
        logic [6:0] kp;
        logic [7:0] b;
        tick(1'b1, id, 1'b0, 8'h0, accept);
        for (int k = 0; k < nbytes; k++) begin
            kp = 7'(k / 2);
            if (junk)            b = 8'hAA;
            else if (k % 2 == 0) b = {id[5:0], kp[6:5]};
            else                 b = {kp[4:0], 3'b000};
            tick(1'b0, 16'h0, 1'b1, b, 1'b0);
        end
    endtask

    task automatic send_rows(input int first, input int last);
        for (int r = first; r <= last; r++) send_packet(16'(r), PB, 1'b1, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_pix"}, {pixel_valid_o, pixel_o, row_o, col_o}, 32'h0);
        chk({tag, "_pulses"}, {frame_done_o, discard_o, resync_o}, 32'h0);
        chk({tag, "_err"}, err_count_o, 32'h0);
    endtask

    initial begin
        reset_i      = 1'b1;
        id_valid_i   = 1'b0;
        id_i         = '0;
        byte_valid_i = 1'b0;
        byte_i       = '0;
        clr_counts();
        repeat (3) @(negedge clk_i);
        check_all_zero("reset");
        reset_i = 1'b0;

        // Startup: non-zero IDs in IDLE are ignored.
        send_packet(16'd12, 10, 1'b0, 1'b0);
        send_packet(16'd13, 10, 1'b0, 1'b0);
        idle(3);
        chk("startup_pix", pix_cnt, 0);
        chk("startup_events", {disc_cnt[7:0], rs_cnt[7:0], fd_cnt[7:0]}, 0);
        chk("startup_err", err_count_o, 0);
        $display("startup: ids 12,13 ignored");

        // Full frame with a discard packet between rows 10 and 11.
        clr_counts();
        for (int r = 0; r < PPF; r++) begin
            send_packet(16'(r), PB, 1'b1, 1'b0);
            if (r == 10) send_packet(16'h0F00, PB, 1'b0, 1'b1);
        end
        idle(3);
        chk("frame1_pix", pix_cnt, 4800);
        chk("frame1_done", fd_cnt, 1);
        chk("frame1_discard", disc_cnt, 1);
        chk("frame1_resync", rs_cnt, 0);
        chk("frame1_err", err_count_o, 0);
        for (int r = 0; r < PPF; r++) chk($sformatf("frame1_row%0d", r), row_pix[r], 80);
        $display("frame1: pixels=%0d done=%0d discards=%0d", pix_cnt, fd_cnt, disc_cnt);

        // Out-of-order: packet 5 followed by packet 7.
        clr_counts();
        send_rows(0, 5);
        send_packet(16'd7, PB, 1'b0, 1'b0);
        idle(3);
        chk("ooo_resync", rs_cnt, 1);
        chk("ooo_err", err_count_o, 1);
        chk("ooo_row7", row_pix[7], 0);
        chk("ooo_pix", pix_cnt, 480);
        $display("out-of-order: resyncs=%0d err=%0d", rs_cnt, err_count_o);
        clr_counts();
        send_rows(0, PPF - 1);
        idle(3);
        chk("frame2_pix", pix_cnt, 4800);
        chk("frame2_done", fd_cnt, 1);
        chk("frame2_resync", rs_cnt, 0);
        chk("frame2_err", err_count_o, 1);
        $display("frame2: pixels=%0d done=%0d", pix_cnt, fd_cnt);

        // Short packet: row 3 has only 100 bytes.
        clr_counts();
        send_rows(0, 2);
        send_packet(16'd3, 100, 1'b1, 1'b0);
        send_packet(16'd4, PB, 1'b0, 1'b0);
        idle(3);
        chk("short_resync", rs_cnt, 1);
        chk("short_err", err_count_o, 2);
        chk("short_row3", row_pix[3], 50);
        chk("short_row4", row_pix[4], 0);
        chk("short_done", fd_cnt, 0);
        $display("short: row3 pixels=%0d err=%0d", row_pix[3], err_count_o);

        // Asynchronous reset in the middle of row 30.
        clr_counts();
        send_rows(0, 29);
        send_packet(16'd30, 40, 1'b1, 1'b0);
        idle(1);
        chk("prereset_pix", pixel_valid_o, 1);
        chk("prereset_err", err_count_o, 2);
        reset_i = 1'b1;
        #1;
        check_all_zero("midreset");
        repeat (2) @(negedge clk_i);
        reset_i = 1'b0;
        clr_counts();
        send_rows(0, PPF - 1);
        idle(3);
        chk("frame3_pix", pix_cnt, 4800);
        chk("frame3_done", fd_cnt, 1);
        chk("frame3_resync", rs_cnt, 0);
        chk("frame3_err", err_count_o, 0);
        $display("after reset: frame pixels=%0d done=%0d", pix_cnt, fd_cnt);

        // Error counter saturation.
        clr_counts();
        for (int i = 0; i < 255; i++) begin
            send_packet(16'd0, 0, 1'b1, 1'b0);
            send_packet(16'd5, 0, 1'b0, 1'b0);
        end
        idle(2);
        chk("sat_255", err_count_o, 255);
        send_packet(16'd0, 0, 1'b1, 1'b0);
        send_packet(16'd5, 0, 1'b0, 1'b0);
        idle(2);
        chk("sat_hold", err_count_o, 255);
        chk("sat_resyncs", rs_cnt, 256);
        $display("saturation: err=%0d resyncs=%0d", err_count_o, rs_cnt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vospi_frame_assembler.md
Name: vospi_frame_assembler

Overview:
- Downstream consumer of the VoSPI packet handler. Takes the captured 16-bit packet ID and the payload byte stream.
- Drops discard packets and checks that packet numbers run in sequence 0..packets_per_frame_p-1.
- Packs big-endian byte pairs into 16-bit pixels tagged with row/column, and pulses frame completion.
- Requests a resync from the SPI front end on any sequence or length violation.

Parameters:
- packets_per_frame_p, 60, video packets per frame (rows).
- payload_bytes_p, 160, payload bytes per packet (even).
- err_width_p, 8, width of saturating error counter.

Ports:
- clk_i  in  1  system clock
- reset_i  in  1  asynchronous active-high reset
- id_valid_i  in  1  one-cycle pulse; id_i holds the new packet ID
- id_i  in  16  packet ID; [15:12] reserved/segment, [11:8]==4'hF means discard packet, [11:0] is the packet number otherwise
- byte_valid_i  in  1  one-cycle pulse per payload byte
- byte_i  in  8  payload byte, MSB-first pixel order
- pixel_valid_o  out  1  pixel_o/row_o/col_o valid this cycle
- pixel_o  out  16  assembled pixel {even byte, odd byte}
- row_o  out  6  packet number of the pixel
- col_o  out  7  pixel index within row, 0..payload_bytes_p/2-1
- frame_done_o  out  1  one-cycle pulse after the last pixel of the frame
- discard_o  out  1  one-cycle pulse when a discard ID is accepted
- resync_o  out  1  one-cycle pulse requesting front-end resync
- err_count_o  out  err_width_p  saturating count of resync events

Behaviour:
- Reset (async): state=IDLE, expected packet=0, byte count=0. All outputs are 0, including err_count_o.
- Row widths: row_o is 6 bits and col_o is 7 bits, sized for the defaults. The implementation must enforce packets_per_frame_p<=64 and payload_bytes_p/2<=128 with an elaboration check.
- Packet number is id_i[11:0]. Discard is id_i[11:8]==4'hF; the discard check takes priority over the number check.
- States: IDLE, RECV, DROP.
- IDLE: waits for id_valid_i.
  - Discard ID: discard_o=1, next state DROP.
  - Number 0: expected=1, next state RECV.
  - Any other number: ignored and stays in IDLE; no resync and no error.
- RECV:
  - Bytes are counted 0..payload_bytes_p-1.
  - Even byte: latched as MSB.
  - Odd byte: pixel_valid_o asserts on the following cycle with pixel={msb,byte}, row=current packet, col=count>>1.
  - Bytes past payload_bytes_p are ignored.
- Packet boundary: the next id_valid_i is checked.
  - If fewer than payload_bytes_p bytes were received, the packet was short: resync_o=1, err_count_o+1, go to IDLE. Any partial MSB is discarded.
  - Discard ID: discard_o=1, go to DROP; the expected number is unchanged.
  - Number == expected: continue in RECV and increment expected.
  - Otherwise: resync_o=1, err_count_o+1, go to IDLE.
- Frame end: when byte payload_bytes_p-1 of packet packets_per_frame_p-1 completes, frame_done_o pulses in the same cycle as that final pixel_valid_o. State then returns to IDLE with expected=0.
- DROP: ignores bytes. On id_valid_i it applies the packet-boundary rules above, excluding the short-packet check. Return target: RECV if a frame is in progress, otherwise IDLE.
- Simultaneous id_valid_i and byte_valid_i: the ID is processed and the byte is dropped. This counts toward the short-packet check.
- byte_valid_i in IDLE is ignored.
- err_count_o saturates at all-ones.
- Latency: pixel_valid_o arrives 1 cycle after the odd byte. resync_o and discard_o arrive 1 cycle after id_valid_i. No backpressure; the downstream must accept every pixel.

Decomposition:
- Package vospi_pkg holds:
  - packet and frame constants
  - discard nibble 4'hF
  - ID field slice helpers
  - state enum typedef (IDLE/RECV/DROP)
- Sub-module vospi_pixel_packer: byte-to-16-bit packer with column counter, clear input and valid output. The FSM, sequence check and error counter stay in the top module.

Test Plan:
- Full frame of IDs 0..59, each with 160 bytes. Pixel k of packet r is {r[5:0],k[6:0],3'b0}.
  - Required: 4800 pixel_valid_o with matching pixel, row and col.
  - Required: one frame_done_o, coincident with row=59 col=79.
- Discard packets: ID 16'h0F00 inserted between packets 10 and 11 with 160 junk bytes.
  - Required: discard_o pulse, no pixels emitted from it, frame still completes with no resync.
- Out-of-order ID: packet 5 followed by packet 7.
  - Required: resync_o pulse, err_count_o=1, no row 7 pixels.
  - Then feed ID 0 with a full frame; required: normal completion.
- Short packet: packet 3 with 100 bytes, then ID 4.
  - Required: resync_o, err_count_o increments, only 50 pixels emitted for row 3.
- Startup in IDLE: IDs 12, 13, then 0.
  - Required: no outputs, no errors, until packet 0 is accepted.
- Edge cases:
  - reset_i asserted mid-row 30: all outputs immediately 0, err_count_o=0, then a fresh frame completes.
  - 256 forced errors: err_count_o stays at 255.
